// File: rtl/tone_pkg.sv
// Shared definitions for the tone sequencer: tone codes, the segment record,
// the FSM state type and the fixed pattern ROM.
package tone_pkg;

    localparam logic [2:0] TONE_KEY    = 3'd0;
    localparam logic [2:0] TONE_ACCEPT = 3'd1;
    localparam logic [2:0] TONE_ERROR  = 3'd2;
    localparam logic [2:0] TONE_REMOVE = 3'd3;
    localparam logic [2:0] TONE_ALERT  = 3'd4;

    localparam int HP_W  = 8;
    localparam int DUR_W = 8;
    localparam int SEG_W = HP_W + DUR_W + 1;
    localparam int CNT_W = 18;

    typedef struct packed {
        logic [HP_W-1:0]  half_period;
        logic [DUR_W-1:0] duration;
        logic             last;
    } seg_t;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    function automatic logic tone_valid(input logic [2:0] tone);
        return tone <= TONE_ALERT;
    endfunction

    // Unused slots decode to a one-unit silent last segment so a stray
    // index can never run away.
    function automatic seg_t seg_rom(input logic [2:0] tone, input logic [1:0] idx);
        seg_t s;
        s = '{half_period: 8'd0, duration: 8'd1, last: 1'b1};
        case ({tone, idx})
            {TONE_KEY,    2'd0}: s = '{8'd24, 8'd20,  1'b1};
            {TONE_ACCEPT, 2'd0}: s = '{8'd32, 8'd30,  1'b0};
            {TONE_ACCEPT, 2'd1}: s = '{8'd20, 8'd30,  1'b1};
            {TONE_ERROR,  2'd0}: s = '{8'd64, 8'd40,  1'b0};
            {TONE_ERROR,  2'd1}: s = '{8'd0,  8'd10,  1'b0};
            {TONE_ERROR,  2'd2}: s = '{8'd64, 8'd40,  1'b1};
            {TONE_REMOVE, 2'd0}: s = '{8'd28, 8'd15,  1'b0};
            {TONE_REMOVE, 2'd1}: s = '{8'd0,  8'd15,  1'b0};
            {TONE_REMOVE, 2'd2}: s = '{8'd28, 8'd15,  1'b0};
            {TONE_REMOVE, 2'd3}: s = '{8'd0,  8'd15,  1'b1};
            {TONE_ALERT,  2'd0}: s = '{8'd16, 8'd255, 1'b1};
            default:             s = '{half_period: 8'd0, duration: 8'd1, last: 1'b1};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Request and DAC-side signals of the tone sequencer.
// Handshake: a request transfers on a clk edge where req_valid & req_ready;
// the requester holds req_valid and req_tone stable until that edge.
interface tone_sequencer_if;
    logic              req_valid;
    logic [2:0]        req_tone;
    logic              req_ready;
    logic              abort;
    logic signed [7:0] sample;
    logic              hush;
    logic              busy;
    logic              done;

    modport master (output req_valid, req_tone, abort,
                    input  req_ready, sample, hush, busy, done);
    modport slave  (input  req_valid, req_tone, abort,
                    output req_ready, sample, hush, busy, done);
endinterface

// File: rtl/tick_prescaler.sv
// Free-running sample-rate divider; tick is high for one clk every DIV clks.
module tick_prescaler #(
    parameter int DIV = 2048
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt_q <= '0;
        else if (tick) cnt_q <= '0;
        else           cnt_q <= cnt_q + W'(1);
    end
endmodule

// File: rtl/tone_sequencer.sv
// Plays a ROM-defined pattern of square-wave tones and silent gaps as a signed
// 8-bit sample stream for the sigma-delta DAC.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int SAMPLE_DIV = 2048,
    parameter int DUR_UNIT   = 256,
    parameter int AMPLITUDE  = 96
) (
    input  logic             clk,
    input  logic             rst_n,
    tone_sequencer_if.slave  bus,
    output state_t           state_dbg
);
    localparam logic [7:0] AMP = 8'(AMPLITUDE);

    logic tick;

    state_t           state_q, state_d;
    logic [2:0]       tone_q, tone_d;
    logic [1:0]       seg_idx_q, seg_idx_d;
    logic [7:0]       sample_q, sample_d;
    logic             hush_q, hush_d;
    logic             done_q, done_d;
    logic [HP_W-1:0]  half_q, half_d;
    logic             last_q, last_d;
    logic [HP_W-1:0]  half_cnt_q, half_cnt_d;
    logic [CNT_W-1:0] dur_cnt_q, dur_cnt_d;

    seg_t             seg;
    logic [DUR_W-1:0] dur_eff;
    logic [CNT_W-1:0] dur_load;

    tick_prescaler #(.DIV(SAMPLE_DIV)) u_pre (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign seg      = seg_rom(tone_q, seg_idx_q);
    assign dur_eff  = (seg.duration == '0) ? DUR_W'(1) : seg.duration;
    assign dur_load = CNT_W'(32'(dur_eff) * DUR_UNIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tone_q     <= '0;
            seg_idx_q  <= '0;
            sample_q   <= '0;
            hush_q     <= 1'b1;
            done_q     <= 1'b0;
            half_q     <= '0;
            last_q     <= 1'b0;
            half_cnt_q <= '0;
            dur_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tone_q     <= tone_d;
            seg_idx_q  <= seg_idx_d;
            sample_q   <= sample_d;
            hush_q     <= hush_d;
            done_q     <= done_d;
            half_q     <= half_d;
            last_q     <= last_d;
            half_cnt_q <= half_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tone_d     = tone_q;
        seg_idx_d  = seg_idx_q;
        sample_d   = sample_q;
        hush_d     = hush_q;
        done_d     = 1'b0;
        half_d     = half_q;
        last_d     = last_q;
        half_cnt_d = half_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    tone_d    = bus.req_tone;
                    seg_idx_d = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    state_d  = IDLE;
                    sample_d = '0;
                    hush_d   = 1'b1;
                end else if (!tone_valid(tone_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = PLAY;
                    hush_d     = 1'b0;
                    sample_d   = (seg.half_period == '0) ? 8'd0 : AMP;
                    half_d     = seg.half_period;
                    last_d     = seg.last;
                    half_cnt_d = seg.half_period;
                    dur_cnt_d  = dur_load;
                end
            end
            PLAY: begin
                if (bus.abort) begin
                    state_d  = IDLE;
                    sample_d = '0;
                    hush_d   = 1'b1;
                end else if (tick) begin
                    // The ending tick hands over to the next segment without a
                    // toggle; LOAD keeps sample/hush so there is no click.
                    if (dur_cnt_q == CNT_W'(1)) begin
                        if (last_q) begin
                            state_d  = IDLE;
                            sample_d = '0;
                            hush_d   = 1'b1;
                            done_d   = 1'b1;
                        end else begin
                            seg_idx_d = seg_idx_q + 2'd1;
                            state_d   = LOAD;
                        end
                    end else begin
                        dur_cnt_d = dur_cnt_q - CNT_W'(1);
                        if (half_q != '0) begin
                            if (half_cnt_q == HP_W'(1)) begin
                                sample_d   = -sample_q;
                                half_cnt_d = half_q;
                            end else begin
                                half_cnt_d = half_cnt_q - HP_W'(1);
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sample    = sample_q;
    assign bus.hush      = hush_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.req_ready = (state_q == IDLE);
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with SAMPLE_DIV=4, DUR_UNIT=4, AMPLITUDE=96.
module tb_tone_sequencer;
  import tone_pkg::*;

  localparam int DIV = 4;

  typedef struct {
    logic [2:0] tone;
    int         ticks;    // sample ticks with hush low
    int         silent;   // of those, ticks with sample 0
    int         changes;  // sample value changes while playing
  } vec_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t state_dbg;
  int     total = 0;
  int     bad = 0;
  int     edges;
  logic [15:0] exp_q[$];
  vec_t   vecs[8];

  tone_sequencer_if bus();

  tone_sequencer #(.SAMPLE_DIV(DIV), .DUR_UNIT(4), .AMPLITUDE(96)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // bench copy of the prescaler phase: tick happens in cycles where edges%4==3
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int s_val();
    return int'($signed(bus.sample));
  endfunction

  // driver: present a request at a negedge with the DUT idle; returns at the
  // negedge of the first cycle after LOAD
  task automatic start_req(input logic [2:0] tone);
    bus.req_valid = 1'b1;
    bus.req_tone  = tone;
    @(negedge clk);
    check("load_busy", int'(bus.busy), 1);
    check("load_hush", int'(bus.hush), 1);
    bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic measure(output int ticks, output int silent, output int changes,
                         output int dones, output int cycles);
    logic       prev_hush;
    logic [7:0] prev_s;
    int         n;
    ticks = 0; silent = 0; changes = 0; dones = 0;
    prev_hush = 1'b1; prev_s = '0; n = 0;
    forever begin
      if (!bus.hush && (edges % DIV) == DIV - 1) begin
        ticks++;
        if (bus.sample == 8'd0) silent++;
      end
      if (!bus.hush && !prev_hush && bus.sample != prev_s) changes++;
      if (bus.done) dones++;
      prev_hush = bus.hush;
      prev_s    = bus.sample;
      if (!bus.busy) break;
      n++;
      if (n > 6000) begin
        total++; bad++;
        $display("FAIL measure_timeout cycles=%0d limit=6000", n);
        break;
      end
      @(negedge clk);
    end
    cycles = n;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
  endtask

  initial begin
    int tk, sl, ch, dn, cy, viol, n, cnt;
    bus.req_valid = 1'b0;
    bus.req_tone  = '0;
    bus.abort     = 1'b0;

    vecs[0] = '{TONE_KEY,    80,   0,   3};
    vecs[1] = '{TONE_ACCEPT, 240,  0,   9};
    vecs[2] = '{TONE_ERROR,  360,  40,  6};
    vecs[3] = '{TONE_REMOVE, 240,  120, 7};
    vecs[4] = '{TONE_ALERT,  1020, 0,   63};
    vecs[5] = '{3'd5,        0,    0,   0};
    vecs[6] = '{3'd6,        0,    0,   0};
    vecs[7] = '{3'd7,        0,    0,   0};

    // reset, then 100 idle cycles
    repeat (3) @(negedge clk);
    check("rst_sample", s_val(), 0);
    check("rst_hush", int'(bus.hush), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ready", int'(bus.req_ready), 1);
    check("rst_done", int'(bus.done), 0);
    check("rst_state", int'(state_dbg), int'(IDLE));
    rst_n = 1'b1;
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.sample != 8'd0 || !bus.hush || bus.busy || !bus.req_ready || bus.done) viol++;
    end
    check("idle_100_cycles_violations", viol, 0);

    // table of patterns, including invalid codes
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(16'(vecs[i].ticks));
      start_req(vecs[i].tone);
      check("latency_hush", int'(bus.hush), (vecs[i].ticks == 0) ? 1 : 0);
      check("first_sample", s_val(), (vecs[i].ticks == 0) ? 0 : 96);
      measure(tk, sl, ch, dn, cy);
      check("play_ticks", tk, int'(exp_q.pop_front()));
      check("silent_ticks", sl, vecs[i].silent);
      check("sample_changes", ch, vecs[i].changes);
      check("done_pulses", dn, 1);
      check("end_hush", int'(bus.hush), 1);
      check("end_sample", s_val(), 0);
      check("end_busy", int'(bus.busy), 0);
    end

    // KEY: done timing relative to the accept edge
    start_req(TONE_KEY);
    measure(tk, sl, ch, dn, cy);
    check("key_done_clk_in_316_324", int'((cy + 2) >= 316 && (cy + 2) <= 324), 1);
    check("key_done_pulses", dn, 1);

    // request held while busy, accepted once IDLE is entered
    start_req(TONE_KEY);
    repeat (10) @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_tone  = TONE_ACCEPT;
    viol = 0; n = 0;
    while (bus.busy && n < 1000) begin
      if (bus.req_ready) viol++;
      @(negedge clk);
      n++;
    end
    check("ready_low_while_busy", viol, 0);
    check("ready_in_idle", int'(bus.req_ready), 1);
    check("key_done_before_accept", int'(bus.done), 1);
    @(negedge clk);
    check("accept_taken_busy", int'(bus.busy), 1);
    bus.req_valid = 1'b0;
    @(negedge clk);
    measure(tk, sl, ch, dn, cy);
    check("queued_accept_ticks", tk, 240);
    check("queued_accept_changes", ch, 9);
    check("queued_accept_done", dn, 1);

    // abort 50 ticks into ALERT
    start_req(TONE_ALERT);
    cnt = 0; n = 0;
    while (cnt < 50 && n < 1000) begin
      if (!bus.hush && (edges % DIV) == DIV - 1) cnt++;
      @(negedge clk);
      n++;
    end
    check("alert_playing_before_abort", int'(bus.hush), 0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_sample", s_val(), 0);
    check("abort_hush", int'(bus.hush), 1);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_state", int'(state_dbg), int'(IDLE));
    dn = int'(bus.done);
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("abort_no_done", dn, 0);

    // abort in IDLE is ignored; simultaneous request is accepted
    bus.abort = 1'b1; bus.req_valid = 1'b1; bus.req_tone = TONE_KEY;
    @(negedge clk);
    check("idle_abort_req_accepted", int'(bus.busy), 1);
    bus.abort = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    check("idle_abort_then_play", int'(bus.hush), 0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_from_play_busy", int'(bus.busy), 0);
    check("abort_from_play_done", int'(bus.done), 0);

    // asynchronous reset mid-PLAY
    start_req(TONE_ERROR);
    repeat (40) @(negedge clk);
    check("error_playing", int'(bus.hush), 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sample", s_val(), 0);
    check("async_rst_hush", int'(bus.hush), 1);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_ready", int'(bus.req_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", int'(state_dbg), int'(IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Upstream audio source for the sigma-delta DAC stage. It takes a tone request code from the ATM control logic and plays a fixed multi-segment pattern: square-wave tones and silent gaps. The pattern is emitted as a signed 8-bit sample updated at the sample rate. `hush` is asserted whenever nothing is playing. Outputs connect directly to the DAC's `sample` / `hush` inputs.

Parameters:
SAMPLE_DIV, 2048, clk cycles per sample tick (minimum 2)
DUR_UNIT, 256, sample ticks per segment-duration unit (minimum 1)
AMPLITUDE, 96, square-wave magnitude, 1..127; output swings between +AMPLITUDE and -AMPLITUDE (two's complement)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
req_valid  in  1  tone request valid
req_tone  in  3  tone code, sampled when req_valid & req_ready
req_ready  out  1  high only in IDLE
abort  in  1  stop current pattern immediately
sample  out  8  signed sample to DAC
hush  out  1  1 = silent/idle (DAC forces 0)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a pattern finishes normally

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values: state=IDLE, sample=0, hush=1, busy=0, done=0, req_ready=1, prescaler=0, all counters=0.
- Prescaler: runs freely from reset, counting 0..SAMPLE_DIV-1. `tick` is asserted in the cycle where count==SAMPLE_DIV-1. Requests never realign it.
- Segment format (from the package ROM): half_period[7:0], duration[7:0], last[0].
  - half_period==0 means a silence segment: sample=0, hush=0.
  - duration==0 is treated as 1.
- Every pattern has at most 4 segments. The last segment has last=1.
- States: IDLE, LOAD, PLAY.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge: latch req_tone, set seg_idx=0, go to LOAD. hush stays 1.
- LOAD (exactly 1 cycle):
  - Read ROM[tone][seg_idx].
  - Valid code (0..4): next edge goes to PLAY and sets:
    - hush<=0
    - sample <= +AMPLITUDE, or 0 for a silence segment
    - half_cnt <= half_period
    - dur_cnt <= duration*DUR_UNIT (18-bit)
  - Invalid code (5..7): return to IDLE, pulse done, hush remains 1.
- PLAY: updates happen only on tick.
  - dur_cnt decrements.
  - For a tone segment, half_cnt decrements. When it reaches 1, sample is negated and half_cnt reloads.
  - On the tick where dur_cnt==1:
    - last=1: go to IDLE, sample<=0, hush<=1, done pulses the following cycle.
    - last=0: seg_idx++, go to LOAD, sample and hush held (no click between segments).
- Latency: accept edge to first non-hush output = 2 clk edges. The segment toggle phase starts at the first tick after PLAY entry.
- Abort:
  - In LOAD or PLAY: next edge goes to IDLE, sample=0, hush=1, no done pulse.
  - In IDLE: ignored. A simultaneous req_valid is accepted.
- New requests are not accepted while busy. The requester holds req_valid, since req_ready=0.
- Reset mid-pattern: immediate return to reset values (asynchronous).
- Arithmetic: the sample toggles by two's-complement negation. AMPLITUDE≤127 guarantees no overflow.

Decomposition:
- Package tone_pkg holds:
  - tone code localparams: TONE_KEY=0, TONE_ACCEPT=1, TONE_ERROR=2, TONE_REMOVE=3, TONE_ALERT=4
  - the segment struct/width constants
  - the pattern ROM function, with entries as {half_period, duration, last}:
    - KEY: {24,20,1}
    - ACCEPT: {32,30,0}, {20,30,1}
    - ERROR: {64,40,0}, {0,10,0}, {64,40,1}
    - REMOVE: {28,15,0}, {0,15,0}, {28,15,0}, {0,15,1}
    - ALERT: {16,255,1}
- One sub-module: tick_prescaler, which produces the free-running tick.

Test Plan:
(Sim parameters SAMPLE_DIV=4, DUR_UNIT=4, AMPLITUDE=96.)
- Reset, idle: rst_n low then high, no request for 100 cycles -> sample=0, hush=1, busy=0, req_ready=1 throughout.
- KEY request:
  - req_tone=0 accepted -> hush=0 two edges later and sample=96 (0x60).
  - sample alternates 0x60/0xA0 every 24 ticks (96 clk).
  - done pulses exactly once after 80 ticks (320±4 clk).
  - Finally hush=1, sample=0.
- ERROR pattern:
  - Observed as 160 ticks of tone (half_period 64).
  - Then 40 ticks with sample=0 and hush=0.
  - Then 160 ticks of tone, then done.
- Abort mid-ALERT: abort pulsed 50 ticks in -> next cycle sample=0, hush=1, busy=0, and done never asserts.
- Request while busy: req_valid for ACCEPT during KEY -> req_ready=0 is held until KEY finishes, then ACCEPT is accepted the edge after IDLE is entered.
- Invalid code, async reset:
  - req_tone=6 -> busy for 1 cycle (LOAD), done pulses, hush stays 1.
  - rst_n dropped mid-PLAY -> outputs reach reset values without waiting for a clk edge.
